// File: rtl/mem_arbiter_pkg.sv
// Shared widths and owner-state encoding for the instruction/data memory arbiter.
// The width macros are only defined here when no project-wide value exists.
`ifndef ADDR
`define ADDR 16
`endif
`ifndef WORD
`define WORD 32
`endif

package mem_arbiter_pkg;

    // Which requester owns the read response arriving next cycle.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD_I = 2'd1,
        RD_D = 2'd2
    } owner_t;

endpackage

// File: rtl/mem_arbiter_starve_cnt.sv
// Counts consecutive cycles a pending instruction request loses arbitration.
// Saturates at LIMIT and flags when the limit is reached.
module arb_starve_cnt #(
    parameter int LIMIT = 4,
    parameter int W     = $clog2(LIMIT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic pend,
    output logic at_limit
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (!pend) begin
            cnt <= '0;
        end else if (cnt != W'(LIMIT)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign at_limit = (cnt == W'(LIMIT));

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous memory between instruction and data ports.
// Optional instruction starvation guard is enabled by defining MEM_ARB_STARVE_EN.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int AW           = `ADDR,
    parameter int DW           = `WORD
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req_i,
    input  logic [AW-1:0] i_addr_i,
    output logic          i_gnt_o,
    output logic          i_valid_o,
    output logic [DW-1:0] i_data_o,
    input  logic          d_req_i,
    input  logic          d_we_i,
    input  logic [AW-1:0] d_addr_i,
    input  logic [DW-1:0] d_wdata_i,
    output logic          d_gnt_o,
    output logic          d_valid_o,
    output logic [DW-1:0] d_rdata_o,
    output logic [AW-1:0] m_addr_o,
    output logic          m_we_o,
    output logic [DW-1:0] m_wdata_o,
    input  logic [DW-1:0] m_rdata_i
);

    owner_t state_q, state_d;
    logic   starve_force;

`ifdef MEM_ARB_STARVE_EN
    arb_starve_cnt #(
        .LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk      (clk),
        .rst      (rst),
        .pend     (i_req_i & ~i_gnt_o),
        .at_limit (starve_force)
    );
`else
    assign starve_force = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = IDLE;
        i_gnt_o   = 1'b0;
        d_gnt_o   = 1'b0;
        i_valid_o = 1'b0;
        d_valid_o = 1'b0;
        i_data_o  = '0;
        d_rdata_o = '0;
        m_addr_o  = '0;
        m_we_o    = 1'b0;
        m_wdata_o = '0;

        // Everything is held at zero during reset, including a response still in flight.
        if (!rst) begin
            if (i_req_i && (!d_req_i || starve_force)) begin
                i_gnt_o = 1'b1;
            end else if (d_req_i) begin
                d_gnt_o = 1'b1;
            end

            if (i_gnt_o) begin
                m_addr_o = i_addr_i;
                state_d  = RD_I;
            end else if (d_gnt_o) begin
                m_addr_o  = d_addr_i;
                m_we_o    = d_we_i;
                m_wdata_o = d_wdata_i;
                state_d   = d_we_i ? IDLE : RD_D;
            end

            i_valid_o = (state_q == RD_I);
            d_valid_o = (state_q == RD_D);
            if (i_valid_o) i_data_o = m_rdata_i;
            if (d_valid_o) d_rdata_o = m_rdata_i;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 1-cycle-latency memory.
// Read responses are predicted into a scoreboard queue at grant time and checked a cycle later.
`ifndef ADDR
`define ADDR 16
`endif
`ifndef WORD
`define WORD 32
`endif

module tb_mem_arbiter;

    localparam int AW = `ADDR;
    localparam int DW = `WORD;
    localparam logic [DW-1:0] MEM10 = 32'hDEAD_BEEF;
    localparam logic [DW-1:0] MEM1  = 32'hA5A5_0001;
    localparam logic [DW-1:0] MEM2  = 32'h5A5A_0002;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req_i;
    logic [AW-1:0] i_addr_i;
    logic          i_gnt_o;
    logic          i_valid_o;
    logic [DW-1:0] i_data_o;
    logic          d_req_i;
    logic          d_we_i;
    logic [AW-1:0] d_addr_i;
    logic [DW-1:0] d_wdata_i;
    logic          d_gnt_o;
    logic          d_valid_o;
    logic [DW-1:0] d_rdata_o;
    logic [AW-1:0] m_addr_o;
    logic          m_we_o;
    logic [DW-1:0] m_wdata_o;
    logic [DW-1:0] m_rdata_i;

    // entry = {i_valid, d_valid, data}
    logic [DW+1:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    logic [DW-1:0] mem [0:255];

    mem_arbiter #(
        .STARVE_LIMIT(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req_i   (i_req_i),
        .i_addr_i  (i_addr_i),
        .i_gnt_o   (i_gnt_o),
        .i_valid_o (i_valid_o),
        .i_data_o  (i_data_o),
        .d_req_i   (d_req_i),
        .d_we_i    (d_we_i),
        .d_addr_i  (d_addr_i),
        .d_wdata_i (d_wdata_i),
        .d_gnt_o   (d_gnt_o),
        .d_valid_o (d_valid_o),
        .d_rdata_o (d_rdata_o),
        .m_addr_o  (m_addr_o),
        .m_we_o    (m_we_o),
        .m_wdata_o (m_wdata_o),
        .m_rdata_i (m_rdata_i)
    );

    always #5 clk = ~clk;

    // Memory contents are (re)loaded while reset is held.
    always @(posedge clk) begin
        if (rst) begin
            mem[8'h10] <= MEM10;
            mem[8'h01] <= MEM1;
            mem[8'h02] <= MEM2;
            mem[8'h20] <= '0;
        end else if (m_we_o) begin
            mem[m_addr_o[7:0]] <= m_wdata_o;
        end
        m_rdata_i <= mem[m_addr_o[7:0]];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic sample(input logic eg_i, input logic eg_d, input logic push,
                          input logic [DW+1:0] entry);
        logic [DW+1:0] e;
        @(negedge clk);
        check("i_gnt", i_gnt_o, eg_i);
        check("d_gnt", d_gnt_o, eg_d);
        e = '0;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        check("i_valid", i_valid_o, e[DW+1]);
        check("d_valid", d_valid_o, e[DW]);
        check("i_data", i_data_o, e[DW+1] ? e[DW-1:0] : '0);
        check("d_rdata", d_rdata_o, e[DW] ? e[DW-1:0] : '0);
        if (push) exp_q.push_back(entry);
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle(input logic eg_i, input logic eg_d, input logic push,
                         input logic [DW+1:0] entry);
        sample(eg_i, eg_d, push, entry);
        advance();
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        check({tag, "_ctrl"}, {i_gnt_o, d_gnt_o, i_valid_o, d_valid_o, m_we_o}, 5'b0);
        check({tag, "_i_data"}, i_data_o, '0);
        check({tag, "_d_rdata"}, d_rdata_o, '0);
        check({tag, "_m_addr"}, m_addr_o, '0);
        check({tag, "_m_wdata"}, m_wdata_o, '0);
        advance();
    endtask

    task automatic idle_inputs();
        i_req_i   = 1'b0;
        i_addr_i  = '0;
        d_req_i   = 1'b0;
        d_we_i    = 1'b0;
        d_addr_i  = '0;
        d_wdata_i = '0;
    endtask

    initial begin
        logic gi;

        // Reset with requests pending: all outputs must read zero.
        rst = 1'b1;
        idle_inputs();
        i_req_i  = 1'b1;
        i_addr_i = 16'h0010;
        d_req_i  = 1'b1;
        d_addr_i = 16'h0002;
        check_reset_outputs("reset0");
        check_reset_outputs("reset1");
        rst = 1'b0;
        idle_inputs();
        cycle(1'b0, 1'b0, 1'b0, '0);

        // Instruction-only read.
        i_req_i  = 1'b1;
        i_addr_i = 16'h0010;
        sample(1'b1, 1'b0, 1'b1, {2'b10, MEM10});
        check("i_rd_m_addr", m_addr_o, 16'h0010);
        check("i_rd_m_we", m_we_o, 1'b0);
        advance();
        idle_inputs();
        cycle(1'b0, 1'b0, 1'b0, '0);

        // Data write then data read of the same address.
        d_req_i   = 1'b1;
        d_we_i    = 1'b1;
        d_addr_i  = 16'h0020;
        d_wdata_i = 32'h1234_5678;
        sample(1'b0, 1'b1, 1'b0, '0);
        check("wr_m_we", m_we_o, 1'b1);
        check("wr_m_addr", m_addr_o, 16'h0020);
        check("wr_m_wdata", m_wdata_o, 32'h1234_5678);
        advance();
        d_we_i    = 1'b0;
        d_wdata_i = '0;
        sample(1'b0, 1'b1, 1'b1, {2'b01, 32'h1234_5678});
        check("rd_m_we", m_we_o, 1'b0);
        advance();
        idle_inputs();
        cycle(1'b0, 1'b0, 1'b0, '0);

        // Simultaneous reads: data first, held instruction next.
        i_req_i  = 1'b1;
        i_addr_i = 16'h0001;
        d_req_i  = 1'b1;
        d_addr_i = 16'h0002;
        sample(1'b0, 1'b1, 1'b1, {2'b01, MEM2});
        check("both_m_addr", m_addr_o, 16'h0002);
        advance();
        d_req_i = 1'b0;
        sample(1'b1, 1'b0, 1'b1, {2'b10, MEM1});
        check("held_m_addr", m_addr_o, 16'h0001);
        advance();
        idle_inputs();
        cycle(1'b0, 1'b0, 1'b0, '0);

        // Continuous contention for 20 cycles.
        i_req_i  = 1'b1;
        i_addr_i = 16'h0001;
        d_req_i  = 1'b1;
        d_addr_i = 16'h0002;
        for (int k = 0; k < 20; k++) begin
`ifdef MEM_ARB_STARVE_EN
            gi = ((k % 5) == 4);
`else
            gi = 1'b0;
`endif
            cycle(gi, ~gi, 1'b1, gi ? {2'b10, MEM1} : {2'b01, MEM2});
        end
        idle_inputs();
        cycle(1'b0, 1'b0, 1'b0, '0);

        // Instruction read granted, then reset: its response must be dropped.
        i_req_i  = 1'b1;
        i_addr_i = 16'h0010;
        cycle(1'b1, 1'b0, 1'b0, '0);
        rst     = 1'b1;
        d_req_i = 1'b1;
        check_reset_outputs("mid_reset");
        rst = 1'b0;
        idle_inputs();
        cycle(1'b0, 1'b0, 1'b0, '0);
        cycle(1'b0, 1'b0, 1'b0, '0);

        check("scoreboard_drain", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
